mem_dump: RTL and testbench

MEM_DUMP -- requirements
Module: mem_dump

---
 rtl/mem_dump_if.sv | 39 +++
 rtl/mem_dump.sv | 176 +++++++++++++++++
 tb/tb_mem_dump.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dump_if.sv
// rtl/mem_dump_if.sv - control, memory-read and output-stream bundle for mem_dump
//
// Signals (directions from the dump engine's side, modport slave):
//   start/abort/base_addr/word_count  in   dump request and cancel
//   mem_addr/mem_re                   out  memory read request
//   mem_rdata                         in   read data, one cycle after mem_re
//   out_data/out_valid/out_last       out  streamed words
//   out_ready                         in   sink acceptance
//   busy/done                         out  status
// The master modport is the mirror image for the requester/sink/memory side.

interface mem_dump_if #(
    parameter int Num_of_bits = 16,
    parameter int Addr_bits   = 20
);
    logic                   start;
    logic                   abort;
    logic [Addr_bits-1:0]   base_addr;
    logic [Addr_bits:0]     word_count;
    logic [Addr_bits-1:0]   mem_addr;
    logic                   mem_re;
    logic [Num_of_bits-1:0] mem_rdata;
    logic [Num_of_bits-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic                   busy;
    logic                   done;

    modport master (
        output start, abort, base_addr, word_count, mem_rdata, out_ready,
        input  mem_addr, mem_re, out_data, out_valid, out_last, busy, done
    );

    modport slave (
        input  start, abort, base_addr, word_count, mem_rdata, out_ready,
        output mem_addr, mem_re, out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/mem_dump.sv
// rtl/mem_dump.sv - streams a block of memory words out through a 2-entry FIFO
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  mem_dump_if.slave: request (start/abort/base_addr/word_count),
//        memory read (mem_addr/mem_re/mem_rdata), output stream
//        (out_data/out_valid/out_ready/out_last), status (busy/done)
//
// Reads are issued in ascending, wrapping address order. Each read's data
// returns one cycle later and is pushed into a two-entry FIFO whose head
// register drives the output stream directly, so the stream holds still
// while the sink stalls.

module mem_dump #(
    parameter int Num_of_bits = 16,
    parameter int Addr_bits   = 20
) (
    input  logic        clk,
    input  logic        rst,
    mem_dump_if.slave   bus
);
    localparam logic [Addr_bits:0] CNT_ONE = {{Addr_bits{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [Addr_bits-1:0]   addr_q,      addr_d;
    logic [Addr_bits:0]     wc_q,        wc_d;
    logic [Addr_bits:0]     issued_q,    issued_d;
    logic                   pend_q,      pend_d;
    logic                   pend_last_q, pend_last_d;

    // FIFO: head entry feeds the output, tail entry holds a second word.
    logic                   h_valid_q,   h_valid_d;
    logic [Num_of_bits-1:0] h_data_q,    h_data_d;
    logic                   h_last_q,    h_last_d;
    logic                   t_valid_q,   t_valid_d;
    logic [Num_of_bits-1:0] t_data_q,    t_data_d;
    logic                   t_last_q,    t_last_d;

    logic                   pop_c;
    logic                   mem_re_c;
    logic [1:0]             occ_c;
    logic [2:0]             used_c;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wc_d        = wc_q;
        issued_d    = issued_q;
        pend_d      = pend_q;
        pend_last_d = pend_last_q;
        h_valid_d   = h_valid_q;
        h_data_d    = h_data_q;
        h_last_d    = h_last_q;
        t_valid_d   = t_valid_q;
        t_data_d    = t_data_q;
        t_last_d    = t_last_q;
        mem_re_c    = 1'b0;

        pop_c  = h_valid_q & bus.out_ready;
        occ_c  = {1'b0, h_valid_q} + {1'b0, t_valid_q};
        // Slots that will be spoken for after this edge if no new read issues.
        used_c = {1'b0, occ_c} + {2'b00, pend_q} - {2'b00, pop_c};

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    addr_d   = bus.base_addr;
                    wc_d     = bus.word_count;
                    issued_d = '0;
                    state_d  = (bus.word_count == '0) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                if (bus.abort) begin
                    // Flush everything, including a read still in flight.
                    state_d     = ST_IDLE;
                    pend_d      = 1'b0;
                    pend_last_d = 1'b0;
                    h_valid_d   = 1'b0;
                    h_data_d    = '0;
                    h_last_d    = 1'b0;
                    t_valid_d   = 1'b0;
                    t_data_d    = '0;
                    t_last_d    = 1'b0;
                end else begin
                    mem_re_c    = (used_c < 3'd2) && (issued_q < wc_q);
                    pend_d      = mem_re_c;
                    pend_last_d = mem_re_c && (issued_q == (wc_q - CNT_ONE));
                    if (mem_re_c) begin
                        addr_d   = addr_q + 1'b1;
                        issued_d = issued_q + CNT_ONE;
                    end

                    if (pop_c) begin
                        h_valid_d = t_valid_q;
                        h_data_d  = t_data_q;
                        h_last_d  = t_last_q;
                        t_valid_d = 1'b0;
                    end

                    // Returning data lands in the first free slot after the pop.
                    if (pend_q) begin
                        if (!h_valid_d) begin
                            h_valid_d = 1'b1;
                            h_data_d  = bus.mem_rdata;
                            h_last_d  = pend_last_q;
                        end else begin
                            t_valid_d = 1'b1;
                            t_data_d  = bus.mem_rdata;
                            t_last_d  = pend_last_q;
                        end
                    end

                    if (pop_c && h_last_q) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wc_q        <= '0;
            issued_q    <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            h_valid_q   <= 1'b0;
            h_data_q    <= '0;
            h_last_q    <= 1'b0;
            t_valid_q   <= 1'b0;
            t_data_q    <= '0;
            t_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wc_q        <= wc_d;
            issued_q    <= issued_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            h_valid_q   <= h_valid_d;
            h_data_q    <= h_data_d;
            h_last_q    <= h_last_d;
            t_valid_q   <= t_valid_d;
            t_data_q    <= t_data_d;
            t_last_q    <= t_last_d;
        end
    end

    assign bus.mem_re    = mem_re_c;
    assign bus.mem_addr  = addr_q;
    assign bus.out_data  = h_data_q;
    assign bus.out_valid = h_valid_q;
    assign bus.out_last  = h_last_q;
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_dump.sv
// tb/tb_mem_dump.sv - self-checking bench for mem_dump

module tb_mem_dump;
    localparam int NB = 16;
    localparam int AW = 20;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   mem_mode = 0;

    mem_dump_if #(.Num_of_bits(NB), .Addr_bits(AW)) bus ();

    mem_dump #(.Num_of_bits(NB), .Addr_bits(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents as seen by the bench.
    function automatic logic [NB-1:0] mem_f(input logic [AW-1:0] a);
        logic [31:0] h;
        if (mem_mode == 0) return a[NB-1:0];
        h = {12'h0, a} * 32'h9E37_79B1;
        return h[31:16] ^ a[15:0];
    endfunction

    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= mem_f(bus.mem_addr);
        else            bus.mem_rdata <= NB'($urandom);
    end

    // Observation log (single writer).
    logic [NB-1:0] got_data[$];
    logic          got_last[$];
    int            got_cyc[$];
    logic [AW-1:0] re_addr[$];
    int            re_cyc[$];
    int            done_cyc[$];
    int            valid_cnt = 0;
    int            stall_err = 0;
    int            ovf_err = 0;
    int            outst = 0;
    logic          prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [NB-1:0] prev_d = '0;

    always @(negedge clk) begin
        logic hs;
        hs = bus.out_valid && bus.out_ready;
        if (hs) begin
            got_data.push_back(bus.out_data);
            got_last.push_back(bus.out_last);
            got_cyc.push_back(cyc);
        end
        if (bus.mem_re) begin
            re_addr.push_back(bus.mem_addr);
            re_cyc.push_back(cyc);
        end
        if (bus.done === 1'b1) done_cyc.push_back(cyc);
        if (bus.out_valid === 1'b1) valid_cnt++;
        if (prev_v && !prev_r &&
            (bus.out_valid !== 1'b1 || bus.out_data !== prev_d || bus.out_last !== prev_l))
            stall_err++;
        if (!rst || (bus.abort && bus.busy)) begin
            outst  = 0;
            prev_v = 1'b0;
        end else begin
            outst = outst + int'(bus.mem_re) - int'(hs);
            if (outst > 2) ovf_err++;
            prev_v = bus.out_valid;
            prev_r = bus.out_ready;
            prev_d = bus.out_data;
            prev_l = bus.out_last;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int pat, input int j);
        if (pat == 0) return 1'b1;
        if (pat == 1) return (j % 3 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete dump, compared against the word list the rules predict.
    task automatic run_dump(input logic [AW-1:0] base, input int cnt, input int pat, input bit poke);
        int d0, r0, dn0, se0, ov0, v0, e0, j, n, nr;
        logic [AW-1:0] a;
        d0 = got_data.size(); r0 = re_addr.size(); dn0 = done_cyc.size();
        se0 = stall_err; ov0 = ovf_err; v0 = valid_cnt;
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.word_count = (AW+1)'(cnt);
        bus.out_ready = 1'b1;
        tick();
        e0 = cyc;
        bus.start = 1'b0;
        bus.base_addr = AW'($urandom);
        bus.word_count = (AW+1)'($urandom_range(1, 50));
        j = 0;
        while (done_cyc.size() == dn0 && j < 400) begin
            bus.out_ready = rdy(pat, j);
            bus.start = (poke && j == 1);
            tick();
            j++;
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        chk("done_seen", 64'(done_cyc.size() > dn0), 64'd1);
        repeat (3) tick();
        chk("done_once", 64'(done_cyc.size() - dn0), 64'd1);
        chk("busy_after", 64'(bus.busy), 64'd0);
        n = got_data.size() - d0;
        nr = re_addr.size() - r0;
        chk("word_count", 64'(n), 64'(cnt));
        chk("read_count", 64'(nr), 64'(cnt));
        for (int i = 0; i < cnt; i++) begin
            a = base + AW'(i);
            if (i < n) begin
                chk("data", 64'(got_data[d0+i]), 64'(mem_f(a)));
                chk("last", 64'(got_last[d0+i]), 64'(i == cnt - 1));
            end
            if (i < nr) chk("mem_addr", 64'(re_addr[r0+i]), 64'(a));
        end
        if (cnt == 0) begin
            chk("done_time_zero", 64'(done_cyc[dn0]), 64'(e0));
            chk("no_valid_zero", 64'(valid_cnt - v0), 64'd0);
        end else if (n == cnt && nr > 0 && done_cyc.size() > dn0) begin
            chk("first_re_time", 64'(re_cyc[r0]), 64'(e0));
            chk("done_time", 64'(done_cyc[dn0]), 64'(got_cyc[d0+cnt-1] + 1));
            if (pat == 0) begin
                chk("first_valid_time", 64'(got_cyc[d0]), 64'(e0 + 2));
                chk("stream_rate", 64'(got_cyc[d0+cnt-1]), 64'(e0 + 1 + cnt));
            end
        end
        chk("stall_stable", 64'(stall_err - se0), 64'd0);
        chk("outstanding", 64'(ovf_err - ov0), 64'd0);
    endtask

    initial begin
        int dn0, v0, d0, j;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.base_addr = '0;
        bus.word_count = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_mem_re", 64'(bus.mem_re), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        rst = 1'b1;
        tick();

        // Directed: straight stream, stalled stream, wrap, empty dump.
        mem_mode = 0;
        run_dump(20'h00010, 4, 0, 1'b0);
        run_dump(20'h00010, 4, 1, 1'b1);
        run_dump(20'hFFFFE, 3, 0, 1'b0);
        run_dump(20'h00020, 0, 0, 1'b0);

        // Abort while idle does nothing.
        dn0 = done_cyc.size();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        tick();
        chk("idle_abort_busy", 64'(bus.busy), 64'd0);
        chk("idle_abort_done", 64'(done_cyc.size() - dn0), 64'd0);

        // Abort after the second handshake of an 8-word dump.
        d0 = got_data.size();
        dn0 = done_cyc.size();
        bus.start = 1'b1;
        bus.base_addr = 20'h00400;
        bus.word_count = 21'd8;
        tick();
        bus.start = 1'b0;
        j = 0;
        while (got_data.size() - d0 < 2 && j < 50) begin
            tick();
            j++;
        end
        chk("abort_reached", 64'(got_data.size() - d0 >= 2), 64'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_mem_re", 64'(bus.mem_re), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        repeat (3) tick();
        chk("abort_no_done", 64'(done_cyc.size() - dn0), 64'd0);
        run_dump(20'h00100, 1, 0, 1'b0);

        // Reset mid-dump with a stalled word on the output; start held alongside.
        mem_mode = 1;
        dn0 = done_cyc.size();
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        bus.base_addr = 20'h12345;
        bus.word_count = 21'd8;
        tick();
        bus.start = 1'b0;
        j = 0;
        while (bus.out_valid !== 1'b1 && j < 20) begin
            tick();
            j++;
        end
        chk("rst_mid_valid_seen", 64'(bus.out_valid), 64'd1);
        rst = 1'b0;
        bus.start = 1'b1;
        tick();
        chk("mid_rst_mem_re", 64'(bus.mem_re), 64'd0);
        chk("mid_rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_out_last", 64'(bus.out_last), 64'd0);
        chk("mid_rst_out_data", 64'(bus.out_data), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_done", 64'(bus.done), 64'd0);
        rst = 1'b1;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        v0 = valid_cnt;
        repeat (5) tick();
        chk("mid_rst_no_done", 64'(done_cyc.size() - dn0), 64'd0);
        chk("mid_rst_no_valid", 64'(valid_cnt - v0), 64'd0);

        // Randomized dumps against the reference word list.
        for (int k = 0; k < 8; k++) begin
            run_dump(AW'($urandom), $urandom_range(1, 12), $urandom_range(0, 2), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
